// File: rtl/rssi_encoder_if.sv
// Request/response bundle for rssi_encoder: anchor/target coordinates in,
// RSSI word (two's complement Q8.12) and squared distance out.
interface rssi_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  ax;
   logic [7:0]  ay;
   logic [7:0]  xt;
   logic [7:0]  yt;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] rssi;
   logic [16:0] dd_out;

   modport master (
      output in_valid, ax, ay, xt, yt, out_ready,
      input  in_ready, out_valid, rssi, dd_out
   );

   modport slave (
      input  in_valid, ax, ay, xt, yt, out_ready,
      output in_ready, out_valid, rssi, dd_out
   );
endinterface

// File: rtl/rssi_encoder.sv
// Sequential RSSI generator: RSSI = -(OFFSET + 10*log10(dd)) in Q8.12, with
// log2 computed bit-serially by repeated squaring of a normalised mantissa.
module rssi_encoder #(
   parameter int FRAC_BITS = 12,
   parameter int MANT_W    = 16,
   parameter int K_LOG     = 12330,
   parameter int OFFSET    = 59
) (
   input  logic          clk,
   input  logic          reset_n,
   rssi_encoder_if.slave bus
);
   localparam int LOG_W  = 5 + FRAC_BITS;
   localparam int PROD_W = LOG_W + 14;
   localparam int CNT_W  = $clog2(FRAC_BITS + 1);
   localparam int SQ_W   = 2 * MANT_W;

   typedef enum logic [2:0] {
      ST_IDLE, ST_DIST, ST_NORM, ST_LOG, ST_SCALE, ST_DONE
   } state_e;

   state_e               state_q;
   logic [7:0]           ax_q, ay_q, xt_q, yt_q;
   logic [16:0]          dd_q;
   logic [16:0]          dd_out_q;
   logic [4:0]           p_q;
   logic [MANT_W-1:0]    m_q;
   logic [FRAC_BITS-1:0] frac_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [PROD_W-1:0]    prod_q;
   logic [19:0]          rssi_q;
   logic                 out_valid_q;

   logic [7:0]           dx_d, dy_d;
   logic [15:0]          dx2_d, dy2_d;
   logic [16:0]          dd_d;
   logic [4:0]           lead_d;
   logic [MANT_W-1:0]    m_norm_d;
   logic [SQ_W-1:0]      sq_d;
   logic                 bit_d;
   logic [MANT_W-1:0]    m_sq_d;
   logic [19:0]          mag_d;

   // NOTE: every always_comb output gets an unconditional value first so no latch can form.
   always_comb begin
      dx_d  = (ax_q >= xt_q) ? (ax_q - xt_q) : (xt_q - ax_q);
      dy_d  = (ay_q >= yt_q) ? (ay_q - yt_q) : (yt_q - ay_q);
      dx2_d = {8'd0, dx_d} * {8'd0, dx_d};
      dy2_d = {8'd0, dy_d} * {8'd0, dy_d};
      dd_d  = {1'b0, dx2_d} + {1'b0, dy2_d};

      lead_d = '0;
      for (int i = 0; i < 17; i++) begin
         if (dd_q[i]) lead_d = 5'(i);
      end
      // Shifting {dd, MANT_W-1 zeros} right by p covers both the p<15 and p=16 cases.
      m_norm_d = MANT_W'({dd_q, {(MANT_W-1){1'b0}}} >> lead_d);

      sq_d   = {{MANT_W{1'b0}}, m_q} * {{MANT_W{1'b0}}, m_q};
      bit_d  = sq_d[SQ_W-1];
      m_sq_d = MANT_W'(bit_d ? (sq_d >> MANT_W) : (sq_d >> (MANT_W - 1)));

      mag_d = 20'(OFFSET << FRAC_BITS) + 20'(prod_q >> FRAC_BITS);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ax_q        <= '0;
         ay_q        <= '0;
         xt_q        <= '0;
         yt_q        <= '0;
         dd_q        <= '0;
         dd_out_q    <= '0;
         p_q         <= '0;
         m_q         <= '0;
         frac_q      <= '0;
         cnt_q       <= '0;
         prod_q      <= '0;
         rssi_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  ax_q    <= bus.ax;
                  ay_q    <= bus.ay;
                  xt_q    <= bus.xt;
                  yt_q    <= bus.yt;
                  state_q <= ST_DIST;
               end
            end
            ST_DIST: begin
               dd_out_q <= dd_d;
               dd_q     <= (dd_d == '0) ? 17'd1 : dd_d;
               state_q  <= ST_NORM;
            end
            ST_NORM: begin
               p_q     <= lead_d;
               m_q     <= m_norm_d;
               frac_q  <= '0;
               cnt_q   <= '0;
               state_q <= ST_LOG;
            end
            ST_LOG: begin
               m_q    <= m_sq_d;
               frac_q <= {frac_q[FRAC_BITS-2:0], bit_d};
               cnt_q  <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(FRAC_BITS - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_SCALE;
               end
            end
            ST_SCALE: begin
               // Two steps: the log2*K multiply is registered before the offset/negate.
               if (cnt_q == '0) begin
                  prod_q <= PROD_W'({p_q, frac_q}) * PROD_W'(K_LOG);
                  cnt_q  <= CNT_W'(1);
               end else begin
                  rssi_q      <= 20'd0 - mag_d;
                  out_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.rssi      = rssi_q;
   assign bus.dd_out    = dd_out_q;
endmodule

// File: tb/tb_rssi_encoder.sv
// Scoreboard bench for rssi_encoder: driver pushes expected results, a negedge
// monitor pops and compares them against the DUT output.
module tb_rssi_encoder;
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   total   = 0;
   int   bad     = 0;
   int   cyc     = 0;

   rssi_encoder_if bus ();

   rssi_encoder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [19:0] rssi;
      logic [16:0] dd;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   bit   showing = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   task automatic check_close(input string name, input logic [19:0] got, input real want, input real tol);
      real g;
      real diff;
      g    = real'($signed(got));
      diff = g - want;
      if (diff < 0.0) diff = -diff;
      total++;
      if (diff > tol) begin
         bad++;
         $display("FAIL %s: got %0.1f want %0.1f (tol %0.1f)", name, g, want, tol);
      end
   endtask

   // Fixed-point result from the arithmetic rules: integer distance, leading-one
   // normalisation, 12 truncating squarings, truncated K scaling, offset, negate.
   function automatic void ref_model(input int ax, input int ay, input int xt, input int yt,
                                     output int dd, output int rssi);
      longint m, s, lq, mag;
      int dx, dy, d, p, frac;
      dx = (ax > xt) ? ax - xt : xt - ax;
      dy = (ay > yt) ? ay - yt : yt - ay;
      dd = dx * dx + dy * dy;
      d  = (dd == 0) ? 1 : dd;
      p  = 0;
      while ((d >> (p + 1)) != 0) p++;
      m    = (longint'(d) << 15) >> p;
      frac = 0;
      for (int i = 0; i < 12; i++) begin
         s = m * m;
         if (s >= 64'sh8000_0000) begin
            frac = 2 * frac + 1;
            m    = s >>> 16;
         end else begin
            frac = 2 * frac;
            m    = s >>> 15;
         end
      end
      lq   = longint'(p) * 4096 + longint'(frac);
      mag  = 59 * 4096 + ((lq * 12330) >>> 12);
      rssi = int'(1048576 - mag);
   endfunction

   function automatic real ideal_lsb(input int dd);
      int d;
      d = (dd == 0) ? 1 : dd;
      return -(59.0 + 10.0 * $log10(real'(d))) * 4096.0;
   endfunction

   // The real-valued bound covers K_LOG rounding (up to ~3.2 LSB near dd=2^17) plus
   // the truncated log2 fraction scaled by 3.01; worst case stays near 10 LSB.
   always @(negedge clk) begin
      if (!reset_n || !bus.out_valid) begin
         showing = 1'b0;
      end else if (!showing) begin
         showing = 1'b1;
         if (sb.size() == 0) begin
            flag("unexpected_output");
         end else begin
            cur = sb.pop_front();
            check("rssi", 64'(bus.rssi), 64'(cur.rssi));
            check("dd_out", 64'(bus.dd_out), 64'(cur.dd));
            check("latency", 64'(cyc - cur.acc), 64'(16));
            check_close("rssi_vs_real", bus.rssi, ideal_lsb(int'(cur.dd)), 12.0);
         end
      end else begin
         check("rssi_hold", 64'(bus.rssi), 64'(cur.rssi));
         check("dd_hold", 64'(bus.dd_out), 64'(cur.dd));
      end
   end

   task automatic send(input int ax, input int ay, input int xt, input int yt,
                       input int force_rssi = -1);
      exp_t e;
      int   dd, r, waited;
      waited = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         flag("in_ready_timeout");
         return;
      end
      ref_model(ax, ay, xt, yt, dd, r);
      e.rssi = (force_rssi >= 0) ? 20'(force_rssi) : 20'(r);
      e.dd   = 17'(dd);
      e.acc  = cyc + 1;
      sb.push_back(e);
      bus.ax       = 8'(ax);
      bus.ay       = 8'(ay);
      bus.xt       = 8'(xt);
      bus.yt       = 8'(yt);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) flag("result_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      bus.in_valid  = 1'b1;
      bus.ax        = 8'd1;
      bus.ay        = 8'd2;
      bus.xt        = 8'd3;
      bus.yt        = 8'd4;
      bus.out_ready = 1'b1;
      reset_n       = 1'b0;

      // Reset held with a pending request
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_rssi", 64'(bus.rssi), 64'(0));
      check("rst_dd_out", 64'(bus.dd_out), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      bus.in_valid = 1'b0;
      reset_n      = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_rst", 64'(bus.in_ready), 64'(1));

      // Directed points with known RSSI words
      send(10, 10, 10, 10, 'hC5000);
      send(11, 10, 10, 10, 'hC5000);
      send(2, 2, 3, 3, 'hC1FD6);
      send(2, 2, 4, 2, 'hBEFAC);
      send(130, 2, 2, 2, 'h9ADB4);
      send(0, 0, 255, 255);
      send(255, 255, 0, 0);
      send(0, 255, 255, 0);
      wait_idle();

      // Backpressure: result held, new requests ignored
      bus.out_ready = 1'b0;
      send(40, 17, 3, 200);
      begin
         int n;
         n = 0;
         while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!bus.out_valid) flag("bp_valid_timeout");
      end
      bus.ax       = 8'd7;
      bus.ay       = 8'd7;
      bus.xt       = 8'd99;
      bus.yt       = 8'd3;
      bus.in_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("bp_out_valid", 64'(bus.out_valid), 64'(1));
         check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 64'(bus.out_valid), 64'(0));
      check("bp_release_ready", 64'(bus.in_ready), 64'(1));

      // Abort during the log phase
      send(5, 9, 200, 100);
      repeat (6) @(negedge clk);
      #1 reset_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check("abort_out_valid", 64'(bus.out_valid), 64'(0));
      check("abort_in_ready", 64'(bus.in_ready), 64'(1));
      check("abort_rssi", 64'(bus.rssi), 64'(0));
      reset_n = 1'b1;
      repeat (25) @(negedge clk);
      check("abort_no_output", 64'(bus.out_valid), 64'(0));
      send(5, 9, 200, 100);
      wait_idle();

      // Random sweep
      for (int i = 0; i < 40; i++) begin
         send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      wait_idle();
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
